// File: rtl/factor_debouncer_pkg.sv
// Shared types and constants for the factor switch front end.
// CLK_HZ is also used by the display timing.
package factor_debouncer_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 25;
  localparam int CLK_HZ              = 2500;

  // Width of a counter that must hold DEBOUNCE_CYCLES-1, never narrower than 1 bit.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/factor_debouncer_if.sv
// Raw switch inputs and conditioned factor outputs of the debouncer.
// master = switch/stimulus side, slave = debouncer.
interface factor_debouncer_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] i_factor_a_raw;
  logic [WIDTH-1:0] i_factor_b_raw;
  logic [WIDTH-1:0] o_factor_a;
  logic [WIDTH-1:0] o_factor_b;
  logic             o_changed;
  logic             o_settling;

  modport master (
    output i_factor_a_raw, i_factor_b_raw,
    input  o_factor_a, o_factor_b, o_changed, o_settling
  );

  modport slave (
    input  i_factor_a_raw, i_factor_b_raw,
    output o_factor_a, o_factor_b, o_changed, o_settling
  );
endinterface

// File: rtl/factor_debouncer_sync_2ff.sv
// Two-flop synchroniser for a bus of asynchronous levels.
// Bits are synchronised independently; the debouncer absorbs any skew between them.
module sync_2ff #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/factor_debouncer.sv
// Synchronises and debounces both factor switch banks as one vector and
// presents a registered factor pair with a one-cycle change pulse.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   STABLE   | synchronised input equals the candidate; nothing is timed
//   SETTLING | candidate differs from history; timing its stable window
module factor_debouncer
  import factor_debouncer_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  factor_debouncer_if.slave  bus
);
  localparam int              VW       = 2 * WIDTH;
  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic [VW-1:0]    raw_vec;
  logic [VW-1:0]    s2;
  logic [VW-1:0]    cand;
  logic [CW-1:0]    cnt;
  state_t           state;
  logic [WIDTH-1:0] factor_a_q;
  logic [WIDTH-1:0] factor_b_q;
  logic             changed_q;
  logic             settling_q;

  assign raw_vec = {bus.i_factor_b_raw, bus.i_factor_a_raw};

  sync_2ff #(.WIDTH(VW)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (raw_vec),
    .q     (s2)
  );

  // cnt holds the number of stable cycles still required; expiry is cnt == 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= STABLE;
      cand       <= '0;
      cnt        <= '0;
      factor_a_q <= '0;
      factor_b_q <= '0;
      changed_q  <= 1'b0;
      settling_q <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      case (state)
        STABLE: begin
          if (s2 != cand) begin
            cand       <= s2;
            cnt        <= CNT_LOAD;
            state      <= SETTLING;
            settling_q <= 1'b1;
          end
        end
        SETTLING: begin
          if (s2 != cand) begin
            cand <= s2;
            cnt  <= CNT_LOAD;
          end else if (cnt == '0) begin
            state      <= STABLE;
            settling_q <= 1'b0;
            // A glitch that returned to the accepted value expires silently.
            if (cand != {factor_b_q, factor_a_q}) begin
              factor_a_q <= cand[WIDTH-1:0];
              factor_b_q <= cand[VW-1:WIDTH];
              changed_q  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state      <= STABLE;
          settling_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_factor_a = factor_a_q;
  assign bus.o_factor_b = factor_b_q;
  assign bus.o_changed  = changed_q;
  assign bus.o_settling = settling_q;
endmodule
